// File: rtl/inv_sqrt_nr.sv
// Multi-cycle fixed-point 1/sqrt(x): normalise, LUT seed, ITERS Newton-Raphson steps, denormalise.
// Optional out_zero flag port is enabled by defining INV_SQRT_ZERO_FLAG_EN.
module inv_sqrt_nr #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int LUT_BITS = 6,
  parameter int ITERS    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] inv_sqrt,
`ifdef INV_SQRT_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic             busy,
  output logic [2:0]       dbg_state
);
  // y carries WIDTH fraction bits so denormalising never needs to shift in unknown bits
  localparam int YF = WIDTH;
  localparam int YW = WIDTH + 2;
  localparam int MW = FRAC + 2;
  localparam int PW = 2 * WIDTH + 4;
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int LN = 2 ** LUT_BITS;
  localparam logic [PW-1:0] THREE = PW'(3) << YF;

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_SEED, S_NR, S_DENORM, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [WIDTH-1:0]      r_x;
  logic                  r_zero;
  logic [MW-1:0]         r_m;
  logic signed [7:0]     r_eh;
  logic [YW-1:0]         r_y;
  logic [CW-1:0]         r_iter;
  logic [WIDTH-1:0]      r_res;

  int                    w_p, w_e, w_s;
  logic [MW-1:0]         w_m;
  logic [LUT_BITS-1:0]   w_idx;
  logic [PW-1:0]         w_yy, w_t1, w_t2, w_d, w_v;
  logic [YW-1:0]         w_ynew;
  logic [WIDTH-1:0]      w_res;
  logic [YW-1:0]         w_lut [LN];

  // Seed entry: index MSB selects octave [1,2) or [2,4); value is 1/sqrt of bin centre.
  function automatic logic [YW-1:0] seed_val(input int idx);
    logic [127:0] c;
    logic [YW-1:0] y, t;
    int h, k;
    h = idx >> (LUT_BITS - 1);
    k = idx & (2 ** (LUT_BITS - 1) - 1);
    c = 128'(2 * (2 ** (LUT_BITS - 1) + k) + 1) << (FRAC - LUT_BITS + h);
    y = '0;
    for (int b = YF; b >= 0; b--) begin
      t = y | (YW'(1) << b);
      if (128'(t) * 128'(t) * c <= (128'(1) << (2 * YF + FRAC))) y = t;
    end
    return y;
  endfunction

  for (genvar g = 0; g < LN; g++) begin : g_lut
    localparam logic [YW-1:0] P_SEED = seed_val(g);
    assign w_lut[g] = P_SEED;
  end

  always_comb begin
    w_p = 0;
    for (int i = 0; i < WIDTH; i++) if (r_x[i]) w_p = i;
    w_e = (w_p - FRAC) & ~1;
    if (w_e >= 0) w_m = MW'(PW'(r_x) >> w_e);
    else          w_m = MW'(PW'(r_x) << (-w_e));
  end

  assign w_idx = r_m[FRAC+1] ? {1'b1, r_m[FRAC -: LUT_BITS-1]}
                             : {1'b0, r_m[FRAC-1 -: LUT_BITS-1]};

  // y * (3 - m*y*y) / 2, all products at double width then truncated
  always_comb begin
    w_yy   = PW'(r_y) * PW'(r_y);
    w_t1   = w_yy >> YF;
    w_t2   = (PW'(r_m) * w_t1) >> FRAC;
    w_d    = (w_t2 >= THREE) ? '0 : THREE - w_t2;
    w_ynew = YW'((PW'(r_y) * w_d) >> (YF + 1));
  end

  always_comb begin
    w_s = (YF - FRAC) + int'(r_eh);
    if (w_s >= 0) w_v = PW'(r_y) >> w_s;
    else          w_v = PW'(r_y) << (-w_s);
    w_res = (|w_v[PW-1:WIDTH]) ? '1 : w_v[WIDTH-1:0];
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready; the source holds
  // valid and data until then. in_ready is high only in IDLE; out_valid is high only in DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = S_NORM;
      S_NORM:   w_next = S_SEED;
      S_SEED:   w_next = S_NR;
      S_NR:     if (r_iter == CW'(ITERS - 1)) w_next = S_DENORM;
      S_DENORM: w_next = S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_zero <= 1'b0;
      r_m    <= '0;
      r_eh   <= '0;
      r_y    <= '0;
      r_iter <= '0;
      r_res  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x    <= x;
          r_zero <= (x == '0);
        end
        S_NORM: if (!r_zero) begin
          r_m  <= w_m;
          r_eh <= 8'(w_e >>> 1);
        end
        S_SEED: begin
          r_iter <= '0;
          if (!r_zero) r_y <= w_lut[w_idx];
        end
        S_NR: begin
          r_iter <= r_iter + 1'b1;
          if (!r_zero) r_y <= w_ynew;
        end
        S_DENORM: r_res <= r_zero ? '1 : w_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign inv_sqrt  = r_res;
  assign dbg_state = r_state;
`ifdef INV_SQRT_ZERO_FLAG_EN
  assign out_zero  = (r_state == S_DONE) && r_zero;
`endif

endmodule

// File: tb/tb_inv_sqrt_nr.sv
// Directed bench for inv_sqrt_nr: reset, latency, known 1/sqrt values, zero, backpressure, mid-op reset.
module tb_inv_sqrt_nr;
  localparam int ITERS = 2;
  localparam int LAT   = ITERS + 3;
  localparam int NV    = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] x = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] inv_sqrt;
  logic [2:0]  dbg_state;
`ifdef INV_SQRT_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  logic [31:0] vec_x   [NV] = '{32'h01000000, 32'h04000000, 32'h00400000, 32'h00000001,
                                32'h00000000, 32'h02000000, 32'h00800000, 32'h03000000,
                                32'h10000000, 32'h00100000, 32'h7FFFFFFF, 32'hFFFFFFFF};
  logic [31:0] vec_exp [NV] = '{32'h01000000, 32'h00800000, 32'h02000000, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h00B504F3, 32'h016A09E6, 32'h0093CD3A,
                                32'h00400000, 32'h04000000, 32'h0016A09E, 32'h00100000};
  int unsigned vec_tol [NV] = '{2, 2, 2, 0, 0, 2, 2, 2, 2, 2, 2, 2};

  inv_sqrt_nr #(.WIDTH(32), .FRAC(24), .LUT_BITS(6), .ITERS(ITERS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inv_sqrt  (inv_sqrt),
`ifdef INV_SQRT_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input int unsigned tol = 0);
    logic [31:0] diff;
    n_total++;
    diff = (got > exp) ? got - exp : exp - got;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h tol=%0d", tag, got, exp, tol);
    end
  endtask

  // driver: accept one operand, then scoreboard the result when out_valid rises
  task automatic run_op(input logic [31:0] xv, input logic [31:0] ev, input int unsigned tol);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    x = xv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = $urandom;
    exp_q.push_back(ev);
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check($sformatf("latency_%08h", xv), cyc, LAT);
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) check($sformatf("result_%08h", xv), inv_sqrt, exp_q.pop_front(), tol);
`ifdef INV_SQRT_ZERO_FLAG_EN
    check($sformatf("out_zero_%08h", xv), out_zero, (xv == 32'h0) ? 1 : 0);
`endif
  endtask

  task automatic finish_op();
    @(posedge clk); #1;
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    int seen;

    #15;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_inv_sqrt", inv_sqrt, 32'h0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < NV; i++) begin
      run_op(vec_x[i], vec_exp[i], vec_tol[i]);
      finish_op();
    end

    // backpressure: result held, new operands ignored
    out_ready = 1'b0;
    run_op(32'h02000000, 32'h00B504F3, 2);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      x = $urandom;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_hold", inv_sqrt, 32'h00B504F3, 2);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_op();

    // reset while iterating
    in_valid = 1'b1;
    x = 32'h01000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_state_nr", dbg_state, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_inv_sqrt", inv_sqrt, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_ghost_out_valid", seen, 0);
    run_op(32'h04000000, 32'h00800000, 2);
    finish_op();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
